quad_decoder_ext: RTL and testbench



---
 rtl/quad_pkg.sv | 24 ++
 rtl/quad_filter.sv | 55 +++++
 rtl/quad_decoder_ext.sv | 102 ++++++++++
 tb/tb_quad_decoder_ext.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared constants and decode helpers for the quadrature decoder.
// Phases are packed as {A, B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00.
package quad_pkg;

    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;
    localparam logic [1:0] MODE_X4 = 2'b10;

    typedef enum logic {
        UNPRIMED = 1'b0,
        RUN      = 1'b1
    } dec_state_t;

    // Exactly one phase changed.
    function automatic logic is_legal_step(input logic [1:0] prev, input logic [1:0] cur);
        return ((prev ^ cur) == 2'b01) || ((prev ^ cur) == 2'b10);
    endfunction

    // For a legal step, A leading B (up) is exactly when old B differs from new A.
    function automatic logic step_is_up(input logic [1:0] prev, input logic [1:0] cur);
        return prev[0] ^ cur[1];
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample glitch filter.
// valid rises once the first stable level after reset has been accepted.
module quad_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic valid
);

    localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

    logic [1:0] sync;
    logic [1:0] fill;
    logic [3:0] cnt;
    logic       same;

    assign same = (sync[1] == level);

    // NOTE: every register here is state, so only non-blocking assignments are used.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b00;
            fill  <= 2'b00;
            cnt   <= 4'd0;
            level <= 1'b0;
            valid <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            fill <= {fill[0], 1'b1};
            // fill keeps post-reset synchroniser contents out of the first acceptance.
            if (fill[1]) begin
                if (!valid) begin
                    if (!same) level <= sync[1];
                    if (same ? (cnt == LAST) : (FILTER_LEN == 1)) begin
                        valid <= 1'b1;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= same ? cnt + 4'd1 : 4'd1;
                    end
                end else if (same) begin
                    cnt <= 4'd0;
                end else if (cnt == LAST) begin
                    level <= sync[1];
                    cnt   <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/quad_decoder_ext.sv
// Quadrature decoder: filtered A/B/index, x1/x2/x4 decode, preset, index zeroing,
// wrap or saturate counting and a sticky illegal-transition flag.
module quad_decoder_ext
    import quad_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 3,
    parameter bit SATURATE   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quadA,
    input  logic             quadB,
    input  logic             index,
    input  logic [1:0]       mode,
    input  logic             idx_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic a_lvl, a_vld, b_lvl, b_vld, i_lvl, i_vld;

    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .reset(reset), .pin(quadA), .level(a_lvl), .valid(a_vld));
    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .reset(reset), .pin(quadB), .level(b_lvl), .valid(b_vld));
    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (.clk(clk), .reset(reset), .pin(index), .level(i_lvl), .valid(i_vld));

    dec_state_t       state, state_nx;
    logic [1:0]       prev_ab, cur_ab;
    logic             idx_prev, idx_armed, idx_rise;
    logic             legal, up, qualify, step_req, illegal;
    logic [WIDTH-1:0] count_nx;

    assign cur_ab   = {a_lvl, b_lvl};
    assign idx_rise = idx_armed & i_lvl & ~idx_prev;

    always_ff @(posedge clk) begin
        if (reset) state <= UNPRIMED;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == UNPRIMED && a_vld && b_vld) state_nx = RUN;
    end

    // NOTE: each combinational output gets a default first so no latch is inferred.
    always_comb begin
        legal   = is_legal_step(prev_ab, cur_ab);
        up      = step_is_up(prev_ab, cur_ab);
        qualify = 1'b0;
        if (|(mode & MODE_X4))   qualify = legal;
        else if (mode == MODE_X2) qualify = legal && (prev_ab[1] != cur_ab[1]);
        else if (mode == MODE_X1) qualify = legal && (prev_ab[1] != cur_ab[1]) && !cur_ab[0];
        step_req = (state == RUN) && qualify;
        illegal  = (state == RUN) && (prev_ab == ~cur_ab);
    end

    always_comb begin
        count_nx = count;
        if (up) count_nx = (SATURATE && count == MAX)   ? count : count + 1'b1;
        else    count_nx = (SATURATE && count == '0)    ? count : count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            dir       <= 1'b0;
            step      <= 1'b0;
            err       <= 1'b0;
            prev_ab   <= 2'b00;
            idx_prev  <= 1'b0;
            idx_armed <= 1'b0;
        end else begin
            // prev_ab takes the first accepted A/B pair while priming, then tracks every cycle.
            if (state == RUN || state_nx == RUN) prev_ab <= cur_ab;
            idx_prev  <= i_lvl;
            idx_armed <= i_vld;

            step <= 1'b0;
            if (load) begin
                count <= load_val;
            end else if (idx_en && idx_rise) begin
                count <= '0;
            end else if (step_req) begin
                count <= count_nx;
                dir   <= up;
                step  <= 1'b1;
            end

            if (illegal)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder_ext.sv
// Drives a wrapping and a saturating decoder with identical pins and compares both
// against a position model built on Gray-code phase arithmetic.
module tb_quad_decoder_ext;

    localparam int FL = 3;

    logic       clk = 1'b0;
    logic       reset, quadA, quadB, index, idx_en, load, err_clr;
    logic [1:0] mode;
    logic [7:0] load_val;
    logic [7:0] count_w, count_s;
    logic       dir_w, dir_s, step_w, step_s, err_w, err_s;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [1:0] exp_ab;
    int         exp_w, exp_s;
    logic       exp_dir, exp_err;

    always #5 clk = ~clk;

    quad_decoder_ext #(.WIDTH(8), .FILTER_LEN(FL), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .quadA(quadA), .quadB(quadB), .index(index),
        .mode(mode), .idx_en(idx_en), .load(load), .load_val(load_val), .err_clr(err_clr),
        .count(count_w), .dir(dir_w), .step(step_w), .err(err_w));

    quad_decoder_ext #(.WIDTH(8), .FILTER_LEN(FL), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .quadA(quadA), .quadB(quadB), .index(index),
        .mode(mode), .idx_en(idx_en), .load(load), .load_val(load_val), .err_clr(err_clr),
        .count(count_s), .dir(dir_s), .step(step_s), .err(err_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_step);
        check({tag, ".count_w"}, 32'(count_w), 32'(exp_w));
        check({tag, ".count_s"}, 32'(count_s), 32'(exp_s));
        check({tag, ".dir_w"},   32'(dir_w),   32'(exp_dir));
        check({tag, ".dir_s"},   32'(dir_s),   32'(exp_dir));
        check({tag, ".err_w"},   32'(err_w),   32'(exp_err));
        check({tag, ".err_s"},   32'(err_s),   32'(exp_err));
        check({tag, ".step_w"},  32'(step_w),  32'(exp_step));
        check({tag, ".step_s"},  32'(step_s),  32'(exp_step));
    endtask

    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // One pin transition; update expected FL+3 clocks after the pin edge.
    task automatic move(input string tag, input logic [1:0] ab, input bit ld,
                        input logic [7:0] ldv, input bit clr);
        int  d;
        bit  a_chg, counts, up_m;
        d      = (gpos(ab) - gpos(exp_ab) + 4) % 4;
        a_chg  = (ab[1] != exp_ab[1]);
        up_m   = (d == 1);
        if (mode[1])          counts = (d == 1 || d == 3);
        else if (mode == 2'b01) counts = (d == 1 || d == 3) && a_chg;
        else                  counts = (d == 1 || d == 3) && a_chg && (ab[0] == 1'b0);

        @(posedge clk); #1;
        {quadA, quadB} = ab;
        repeat (FL + 2) @(posedge clk);
        #1;
        check({tag, ".early_step"}, 32'(step_w), 32'(0));
        if (ld) begin load = 1'b1; load_val = ldv; end
        if (clr) err_clr = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        err_clr = 1'b0;

        if (ld) begin
            exp_w = ldv;
            exp_s = ldv;
        end else if (counts) begin
            exp_dir = up_m;
            exp_w   = (exp_w + (up_m ? 1 : 255)) % 256;
            exp_s   = up_m ? ((exp_s < 255) ? exp_s + 1 : 255) : ((exp_s > 0) ? exp_s - 1 : 0);
        end
        if (d == 2)   exp_err = 1'b1;
        else if (clr) exp_err = 1'b0;
        exp_ab = ab;
        check_all(tag, counts && !ld);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        @(posedge clk); #1;
        load = 1'b1;
        load_val = v;
        @(posedge clk); #1;
        load = 1'b0;
        exp_w = v;
        exp_s = v;
        check("load.count_w", 32'(count_w), 32'(exp_w));
        check("load.count_s", 32'(count_s), 32'(exp_s));
    endtask

    task automatic glitch(input bit on_a);
        int steps;
        steps = 0;
        @(posedge clk); #1;
        if (on_a) quadA = ~quadA; else quadB = ~quadB;
        repeat (2) @(posedge clk);
        #1;
        if (on_a) quadA = ~quadA; else quadB = ~quadB;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            steps += int'(step_w) + int'(step_s);
        end
        check("glitch.steps", 32'(steps), 32'(0));
        check_all("glitch", 1'b0);
    endtask

    initial begin
        logic [1:0] up_seq [4];
        logic [1:0] dn_seq [4];
        up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        dn_seq = '{2'b01, 2'b11, 2'b10, 2'b00};

        reset = 1'b1; quadA = 1'b0; quadB = 1'b0; index = 1'b0; idx_en = 1'b0;
        load = 1'b0; err_clr = 1'b0; mode = 2'b10; load_val = 8'd0;
        exp_ab = 2'b00; exp_w = 0; exp_s = 0; exp_dir = 1'b0; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        // x4 up: 16 steps
        mode = 2'b10;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) move("x4_up", up_seq[k], 1'b0, 8'd0, 1'b0);
        check("x4_up.total", 32'(count_w), 32'd16);
        check("x4_up.dir", 32'(dir_w), 32'd1);

        // x1 then x2 down from 5
        do_load(8'd5);
        mode = 2'b00;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 4; k++) move("x1_dn", dn_seq[k], 1'b0, 8'd0, 1'b0);
        check("x1_dn.total", 32'(count_w), 32'd2);
        do_load(8'd5);
        mode = 2'b01;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 4; k++) move("x2_dn", dn_seq[k], 1'b0, 8'd0, 1'b0);
        check("x2_dn.wrap", 32'(count_w), 32'd255);
        check("x2_dn.sat", 32'(count_s), 32'd0);

        // saturation at top, then glitches
        mode = 2'b10;
        do_load(8'hFE);
        for (int k = 0; k < 4; k++) move("sat_up", up_seq[k], 1'b0, 8'd0, 1'b0);
        check("sat_up.total", 32'(count_s), 32'hFF);
        glitch(1'b1);
        glitch(1'b0);

        // illegal transition, clear, clear colliding with a new illegal
        move("illegal", 2'b11, 1'b0, 8'd0, 1'b0);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err = 1'b0;
        check("err_clr", 32'(err_w), 32'd0);
        move("illegal_clr", 2'b00, 1'b0, 8'd0, 1'b1);

        // index zeroing, then load racing a step
        do_load(8'd37);
        idx_en = 1'b1;
        @(posedge clk); #1;
        index = 1'b1;
        repeat (FL + 3) @(posedge clk);
        #1;
        exp_w = 0;
        exp_s = 0;
        check_all("index", 1'b0);
        repeat (2) @(posedge clk);
        #1;
        index = 1'b0;
        repeat (8) @(posedge clk);
        idx_en = 1'b0;
        move("load_step", 2'b10, 1'b1, 8'h5A, 1'b0);

        // reset mid-rotation with pins at 11
        move("pre_reset", 2'b11, 1'b0, 8'd0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_w = 0; exp_s = 0; exp_dir = 1'b0; exp_err = 1'b0;
        check_all("mid_reset", 1'b0);
        reset = 1'b0;
        begin
            int spurious;
            spurious = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk); #1;
                spurious += int'(step_w) + int'(err_w) + int'(step_s) + int'(err_s);
            end
            check("reprime.quiet", 32'(spurious), 32'd0);
        end
        move("post_reset", 2'b01, 1'b0, 8'd0, 1'b0);

        // randomized moves, modes, loads and clears
        for (int n = 0; n < 80; n++) begin
            logic [1:0] flip;
            mode = 2'($urandom_range(0, 3));
            flip = ($urandom_range(0, 99) < 85) ? 2'(1 << $urandom_range(0, 1)) : 2'b11;
            move("rand", exp_ab ^ flip, ($urandom_range(0, 9) == 0),
                 8'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
